cpu_mem_responder: RTL and testbench
====================================

# cpu_mem_responder

Memory-side responder for the CPU's two memory ports: it answers the 64-bit instruction-fetch port and the 32-bit data load/store port. Both ports are served from one shared 32-bit backing-memory port (pmem). It sits directly below the cpu top and provides the resp/rdata handshake the core expects. It arbitrates conflicting requests, splits each fetch into two 32-bit beats, and registers every response.

## Interface
- rr_en, default 1: 1 = alternate on inst/data conflict; 0 = data always wins.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low (0 = reset).
- inst_read  in  1  fetch request, held until inst_mem_resp.
- inst_mem_address  in  32  fetch address; bits [2:0] ignored.
- inst_mem_resp  out  1  one-cycle fetch completion pulse.
- inst_mem_rdata  out  64  {word at base+4, word at base}; valid while inst_mem_resp=1.
- data_read  in  1  load request, held until data_mem_resp.
- data_write  in  1  store request, held until data_mem_resp.
- data_mbe  in  4  store byte enables.
- data_mem_address  in  32  load/store address; bits [1:0] ignored.
- data_mem_wdata  in  32  store data.
- data_mem_resp  out  1  one-cycle load/store completion pulse.
- data_mem_rdata  out  32  load data; valid while data_mem_resp=1.
- pmem_read  out  1  backing read strobe, held until pmem_resp.
- pmem_write  out  1  backing write strobe, held until pmem_resp.
- pmem_address  out  32  word-aligned address ([1:0]=0).
- pmem_wdata  out  32  write data.
- pmem_mbe  out  4  write byte enables.
- pmem_resp  in  1  one-cycle completion from backing memory.
- pmem_rdata  in  32  read data; valid with pmem_resp.

## Operation
- States:
  - IDLE: sample requests.
  - I_LO: fetch low beat at {addr[31:3],3'b000}.
  - I_HI: fetch high beat at base+4.
  - D_RD: load.
  - D_WR: store.
  - RESP: drive the registered response.
- IDLE transitions:
  - Only inst_read=1 -> I_LO.
  - Only a data request -> D_RD or D_WR.
  - Both pending, rr_en=1: the port not granted last wins. Data wins on the first conflict after reset.
  - Both pending, rr_en=0: data wins.
- data_write wins over data_read if both are asserted (illegal core behaviour, defined for safety).
- Request address, wdata and mbe are latched on the IDLE->service transition. Later input changes are ignored until RESP.
- pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_mbe are held stable from state entry until pmem_resp. The transition out of the state happens on that same edge.
- pmem_rdata is captured into the low-word register (I_LO), high-word register (I_HI) or data register (D_RD) on pmem_resp.
- I_LO + pmem_resp -> I_HI. I_HI, D_RD or D_WR + pmem_resp -> RESP.
- RESP:
  - Assert exactly one of inst_mem_resp/data_mem_resp for one cycle.
  - Update the last-granted pointer.
  - Go to IDLE.
- pmem_mbe = 4'b0000 on reads.
- A request still held in IDLE after its resp is treated as a new request. The core must drop or replace its request the cycle after resp.

## Timing
- Reset (async assert, synchronous release) sets:
  - state = IDLE, last-granted = inst;
  - all strobes and resp outputs = 0;
  - inst_mem_rdata, data_mem_rdata, pmem_address, pmem_wdata and pmem_mbe = 0.
- Reset mid-transfer: pmem strobes drop immediately and no response is issued. A late pmem_resp after release is ignored in IDLE.
- Request seen in IDLE at cycle 0 -> pmem strobe asserted from cycle 1.
- With zero-wait pmem (pmem_resp in the strobe's first cycle):
  - load/store: data_mem_resp at cycle 2;
  - fetch: inst_mem_resp at cycle 3.
- Each extra pmem wait cycle per beat adds one cycle.
- IDLE may accept a new request in the cycle after RESP. Back-to-back loads therefore take 3 cycles each.
- pmem_resp outside I_LO/I_HI/D_RD/D_WR is ignored.
- No combinational path from any input to any output.

## Test plan
- Fetch at 0x0000_0064, pmem returns 0x11111111 @0x60 and 0x22222222 @0x64 with zero wait:
  - pmem_address = 0x60 at cycle 1, 0x64 at cycle 2;
  - inst_mem_resp at cycle 3 with rdata 0x22222222_11111111.
- Store to 0x0000_1003, wdata 0xAABBCCDD, mbe 4'b1000, pmem_resp after 3 waits:
  - pmem_address 0x1000, mbe 1000, strobe high for 4 cycles;
  - single data_mem_resp pulse.
- Fetch and load asserted together from reset, rr_en=1:
  - load served first, then fetch;
  - repeat with both still pending: fetch first, then load.
  - With rr_en=0, data is always served first.
- Load at 0x2000 returning 0xDEADBEEF, core reissues a load at 0x2004 the cycle after resp:
  - second pmem strobe at 0x2004 begins 3 cycles after the first;
  - no duplicate response.
- Assert rst low while in I_HI:
  - pmem_read falls asynchronously and inst_mem_resp never pulses;
  - after release, pmem_resp=1 in IDLE produces no response.
- data_read and data_write both high: pmem_write issued, pmem_read stays 0.

Source files
------------

// File: rtl/cpu_mem_responder_if.sv
// Bundle of the core-side instruction/data ports and the shared 32-bit
// backing-memory port served by cpu_mem_responder.
interface cpu_mem_responder_if;
  // Handshake: a requester raises its strobe (inst_read, data_read/data_write,
  // pmem_read/pmem_write) together with address/data and holds all of them
  // unchanged until the matching one-cycle resp pulse; that pulse is both the
  // acceptance and the completion, and rdata is valid only in that cycle.
  logic        inst_read;
  logic [31:0] inst_mem_address;
  logic        inst_mem_resp;
  logic [63:0] inst_mem_rdata;

  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_mem_address;
  logic [31:0] data_mem_wdata;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;

  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_mbe;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  modport slave (
    input  inst_read, inst_mem_address,
    output inst_mem_resp, inst_mem_rdata,
    input  data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
    output data_mem_resp, data_mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_mbe,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output inst_read, inst_mem_address,
    input  inst_mem_resp, inst_mem_rdata,
    output data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
    input  data_mem_resp, data_mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_mbe,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Serves the 64-bit fetch port and 32-bit load/store port from one 32-bit
// backing memory: arbitration, two-beat fetch split and registered responses.
module cpu_mem_responder #(
  parameter bit rr_en = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_mem_responder_if.slave   bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_LO = 3'd1,
    I_HI = 3'd2,
    D_RD = 3'd3,
    D_WR = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        last_inst_q;
  logic        svc_inst_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mbe_q;
  logic [31:0] lo_q, hi_q, dword_q;
  logic        data_req;
  logic        data_wins;

  assign data_req  = bus.data_read | bus.data_write;
  // Data loses a conflict only when round-robin is on and data was served last.
  assign data_wins = data_req & (~bus.inst_read | ~rr_en | last_inst_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (data_wins)          state_d = bus.data_write ? D_WR : D_RD;
        else if (bus.inst_read) state_d = I_LO;
      end
      I_LO:             if (bus.pmem_resp) state_d = I_HI;
      I_HI, D_RD, D_WR: if (bus.pmem_resp) state_d = RESP;
      RESP:             state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_inst_q <= 1'b1;
      svc_inst_q  <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      mbe_q       <= 4'h0;
      lo_q        <= 32'h0;
      hi_q        <= 32'h0;
      dword_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d != IDLE) begin
        svc_inst_q <= (state_d == I_LO);
        addr_q     <= (state_d == I_LO) ? (bus.inst_mem_address & 32'hFFFF_FFF8)
                                        : (bus.data_mem_address & 32'hFFFF_FFFC);
        wdata_q    <= bus.data_mem_wdata;
        mbe_q      <= bus.data_mbe;
      end
      if (bus.pmem_resp) begin
        case (state_q)
          I_LO:    lo_q    <= bus.pmem_rdata;
          I_HI:    hi_q    <= bus.pmem_rdata;
          D_RD:    dword_q <= bus.pmem_rdata;
          default: ;
        endcase
      end
      if (state_q == RESP) last_inst_q <= svc_inst_q;
    end
  end

  // Every output is decoded from registers only, so no input reaches an output.
  assign bus.pmem_read      = (state_q == I_LO) | (state_q == I_HI) | (state_q == D_RD);
  assign bus.pmem_write     = (state_q == D_WR);
  assign bus.pmem_address   = addr_q | {29'h0, (state_q == I_HI), 2'b00};
  assign bus.pmem_wdata     = wdata_q;
  assign bus.pmem_mbe       = (state_q == D_WR) ? mbe_q : 4'h0;
  assign bus.inst_mem_resp  = (state_q == RESP) &  svc_inst_q;
  assign bus.data_mem_resp  = (state_q == RESP) & ~svc_inst_q;
  assign bus.inst_mem_rdata = {hi_q, lo_q};
  assign bus.data_mem_rdata = dword_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized bench for cpu_mem_responder: behavioural memory + scoreboard
// for the round-robin instance, plus a short data-priority check on rr_en=0.
module tb_cpu_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_mem_responder_if bus();
  cpu_mem_responder_if bus_f();
  logic [2:0] dbg, dbg_f;

  cpu_mem_responder #(.rr_en(1'b1)) dut   (.clk(clk), .rst(rst), .bus(bus),   .dbg_state(dbg));
  cpu_mem_responder #(.rr_en(1'b0)) dut_f (.clk(clk), .rst(rst), .bus(bus_f), .dbg_state(dbg_f));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- memories and reference model ----------------
  logic [31:0] pmem_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] pm_rd(input logic [31:0] a);
    return pmem_mem.exists(a) ? pmem_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] mbe);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (mbe[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction
  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    pmem_mem[a] = v;
    ref_mem[a]  = v;
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
  } beat_t;

  beat_t       exp_beat_q[$];
  logic [63:0] exp_q[$];
  logic [32:0] exp_dq[$];

  // ---------------- backing memory model ----------------
  int    wait_n = 0;
  bit    force_resp = 1'b0;
  int    pm_cnt = 0;
  int    last_start = 0, prev_start = 0;
  beat_t cur_beat, obs, e_beat;

  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      obs.addr = bus.pmem_address; obs.rd = bus.pmem_read; obs.wr = bus.pmem_write;
      obs.mbe  = bus.pmem_mbe;     obs.wdata = bus.pmem_wdata;
      if (bus.pmem_read || bus.pmem_write) begin
        if (pm_cnt == 0) begin
          cur_beat   = obs;
          prev_start = last_start;
          last_start = cyc;
        end else begin
          check_eq("pmem_hold_addr", 64'(obs.addr), 64'(cur_beat.addr));
          check_eq("pmem_hold_ctl", 64'({obs.rd, obs.wr, obs.mbe, obs.wdata}),
                   64'({cur_beat.rd, cur_beat.wr, cur_beat.mbe, cur_beat.wdata}));
        end
        if (pm_cnt >= wait_n) begin
          check_eq("pmem_beat_expected", 64'(exp_beat_q.size() != 0), 64'd1);
          if (exp_beat_q.size() != 0) begin
            e_beat = exp_beat_q.pop_front();
            check_eq("pmem_addr", 64'(obs.addr), 64'(e_beat.addr));
            check_eq("pmem_rd_wr_mbe", 64'({obs.rd, obs.wr, obs.mbe}),
                     64'({e_beat.rd, e_beat.wr, e_beat.mbe}));
            if (e_beat.wr) check_eq("pmem_wdata", 64'(obs.wdata), 64'(e_beat.wdata));
          end
          if (obs.wr) pmem_mem[obs.addr] = merge(pm_rd(obs.addr), obs.wdata, obs.mbe);
          bus.pmem_rdata = obs.wr ? $urandom : pm_rd(obs.addr);
          bus.pmem_resp  = 1'b1;
          pm_cnt = 0;
        end else begin
          pm_cnt++;
        end
      end else begin
        pm_cnt = 0;
        if (force_resp) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = $urandom;
        end
      end
    end
  end

  // Zero-wait memory for the rr_en=0 instance: each word reads as address ^ key.
  localparam logic [31:0] KEY = 32'hF0F0_0000;
  initial begin
    bus_f.pmem_resp  = 1'b0;
    bus_f.pmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus_f.pmem_resp  = bus_f.pmem_read | bus_f.pmem_write;
      bus_f.pmem_rdata = bus_f.pmem_address ^ KEY;
    end
  end

  // ---------------- response scoreboard ----------------
  logic [63:0] ev;
  logic [32:0] dv;
  always @(negedge clk) begin
    if (bus.inst_mem_resp || bus.data_mem_resp)
      check_eq("resp_exclusive", 64'(bus.inst_mem_resp & bus.data_mem_resp), 64'd0);
    if (bus.inst_mem_resp) begin
      check_eq("inst_resp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        check_eq("inst_rdata", bus.inst_mem_rdata, ev);
      end
    end
    if (bus.data_mem_resp) begin
      check_eq("data_resp_expected", 64'(exp_dq.size() != 0), 64'd1);
      if (exp_dq.size() != 0) begin
        dv = exp_dq.pop_front();
        if (dv[32]) check_eq("data_rdata", 64'(bus.data_mem_rdata), 64'(dv[31:0]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic start_fetch(input logic [31:0] a);
    logic [31:0] b;
    beat_t e;
    b = a & 32'hFFFF_FFF8;
    e = '0; e.rd = 1'b1;
    e.addr = b;      exp_beat_q.push_back(e);
    e.addr = b + 4;  exp_beat_q.push_back(e);
    exp_q.push_back({ref_rd(b + 4), ref_rd(b)});
    bus.inst_read = 1'b1;
    bus.inst_mem_address = a;
  endtask

  // kind: 1 load, 2 store, 3 load+store strobes together (store expected)
  task automatic start_data(input int kind, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] mbe);
    logic [31:0] w;
    beat_t e;
    w = a & 32'hFFFF_FFFC;
    e = '0; e.addr = w; e.rd = (kind == 1); e.wr = (kind != 1);
    e.mbe = (kind == 1) ? 4'h0 : mbe; e.wdata = wd;
    exp_beat_q.push_back(e);
    if (kind == 1) exp_dq.push_back({1'b1, ref_rd(w)});
    else begin
      exp_dq.push_back({1'b0, 32'h0});
      ref_mem[w] = merge(ref_rd(w), wd, mbe);
    end
    bus.data_read = (kind != 2);
    bus.data_write = (kind != 1);
    bus.data_mem_address = a;
    bus.data_mem_wdata = wd;
    bus.data_mbe = mbe;
  endtask

  task automatic drop_inst();
    bus.inst_read = 1'b0;
    bus.inst_mem_address = $urandom;
  endtask
  task automatic drop_data();
    bus.data_read = 1'b0; bus.data_write = 1'b0;
    bus.data_mem_address = $urandom; bus.data_mem_wdata = $urandom; bus.data_mbe = 4'($urandom);
  endtask

  task automatic wait_any(output bit got_inst, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.inst_mem_resp && !bus.data_mem_resp && lat < 60);
    check_eq("resp_seen", 64'(bus.inst_mem_resp | bus.data_mem_resp), 64'd1);
    got_inst = bus.inst_mem_resp;
  endtask

  task automatic wait_f(output bit got_inst, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus_f.inst_mem_resp && !bus_f.data_mem_resp && lat < 60);
    check_eq("f_resp_seen", 64'(bus_f.inst_mem_resp | bus_f.data_mem_resp), 64'd1);
    got_inst = bus_f.inst_mem_resp;
  endtask

  // One isolated transaction; DUT is idle at entry and again on return.
  task automatic do_seq(input int kind, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] mbe, input int w);
    bit gi;
    int lat;
    wait_n = w;
    if (kind == 0) start_fetch(a);
    else start_data(kind, a, wd, mbe);
    wait_any(gi, lat);
    check_eq("served_port", 64'(gi), 64'(kind == 0));
    check_eq("latency", 64'(lat), (kind == 0) ? 64'(3 + 2 * w) : 64'(2 + w));
    if (kind == 0) drop_inst(); else drop_data();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_beat_q.delete(); exp_q.delete(); exp_dq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    summary();
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    bit          gi;
    int          lat, s1, k, kind, w;
    logic [31:0] tmp, a;

    rst = 1'b0;
    bus.inst_read = 0; bus.inst_mem_address = 0;
    bus.data_read = 0; bus.data_write = 0; bus.data_mbe = 0;
    bus.data_mem_address = 0; bus.data_mem_wdata = 0;
    bus_f.inst_read = 0; bus_f.inst_mem_address = 0;
    bus_f.data_read = 0; bus_f.data_write = 0; bus_f.data_mbe = 0;
    bus_f.data_mem_address = 0; bus_f.data_mem_wdata = 0;
    repeat (3) @(negedge clk);

    check_eq("rst_inst_resp",  64'(bus.inst_mem_resp), 64'd0);
    check_eq("rst_data_resp",  64'(bus.data_mem_resp), 64'd0);
    check_eq("rst_pmem_read",  64'(bus.pmem_read), 64'd0);
    check_eq("rst_pmem_write", 64'(bus.pmem_write), 64'd0);
    check_eq("rst_inst_rdata", bus.inst_mem_rdata, 64'd0);
    check_eq("rst_data_rdata", 64'(bus.data_mem_rdata), 64'd0);
    check_eq("rst_pmem_addr",  64'(bus.pmem_address), 64'd0);
    check_eq("rst_pmem_wdata", 64'(bus.pmem_wdata), 64'd0);
    check_eq("rst_pmem_mbe",   64'(bus.pmem_mbe), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Fetch at 0x64 with zero wait
    set_word(32'h60, 32'h1111_1111);
    set_word(32'h64, 32'h2222_2222);
    wait_n = 0;
    start_fetch(32'h0000_0064);
    wait_any(gi, lat);
    check_eq("fetch_port", 64'(gi), 64'd1);
    check_eq("fetch_latency", 64'(lat), 64'd3);
    check_eq("fetch_rdata", bus.inst_mem_rdata, 64'h2222_2222_1111_1111);
    check_eq("fetch_beat_gap", 64'(last_start - prev_start), 64'd1);
    drop_inst();
    @(negedge clk);

    // Store with 3 waits, then read back to see the byte merge
    do_seq(2, 32'h0000_1003, 32'hAABB_CCDD, 4'b1000, 3);
    tmp = init_word(32'h1000);
    do_seq(1, 32'h0000_1000, 32'h0, 4'h0, 0);
    check_eq("store_merge", 64'(ref_rd(32'h1000)), 64'({8'hAA, tmp[23:0]}));

    // Back-to-back loads: second issued in the resp cycle of the first
    set_word(32'h2000, 32'hDEAD_BEEF);
    wait_n = 0;
    start_data(1, 32'h0000_2000, 32'h0, 4'h0);
    wait_any(gi, lat);
    check_eq("b2b_first_latency", 64'(lat), 64'd2);
    check_eq("b2b_first_rdata", 64'(bus.data_mem_rdata), 64'hDEAD_BEEF);
    s1 = last_start;
    start_data(1, 32'h0000_2004, 32'h0, 4'h0);
    wait_any(gi, lat);
    check_eq("b2b_second_latency", 64'(lat), 64'd3);
    check_eq("b2b_strobe_spacing", 64'(last_start - s1), 64'd3);
    drop_data();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("b2b_no_dup", 64'(bus.data_mem_resp | bus.inst_mem_resp), 64'd0);
    end

    // Both data strobes: the store must win, no read strobe
    do_seq(3, 32'h0000_1008, 32'h1234_5678, 4'b0110, 1);

    // Conflicts with round-robin, starting from reset
    do_reset();
    wait_n = 0;
    start_data(1, 32'h0000_1100, 32'h0, 4'h0);
    start_fetch(32'h0000_0200);
    wait_any(gi, lat);
    check_eq("rr_first_is_data", 64'(gi), 64'd0);
    check_eq("rr_first_latency", 64'(lat), 64'd2);
    start_data(1, 32'h0000_1104, 32'h0, 4'h0);
    wait_any(gi, lat);
    check_eq("rr_second_is_inst", 64'(gi), 64'd1);
    check_eq("rr_second_latency", 64'(lat), 64'd4);
    drop_inst();
    wait_any(gi, lat);
    check_eq("rr_third_is_data", 64'(gi), 64'd0);
    check_eq("rr_third_latency", 64'(lat), 64'd3);
    drop_data();
    @(negedge clk);

    // Fixed data priority on the rr_en=0 instance
    bus_f.inst_read = 1'b1; bus_f.inst_mem_address = 32'h0000_0300;
    bus_f.data_read = 1'b1; bus_f.data_mem_address = 32'h0000_1200;
    wait_f(gi, lat);
    check_eq("fix_first_is_data", 64'(gi), 64'd0);
    check_eq("fix_first_rdata", 64'(bus_f.data_mem_rdata), 64'(32'h0000_1200 ^ KEY));
    bus_f.data_mem_address = 32'h0000_1204;
    wait_f(gi, lat);
    check_eq("fix_second_is_data", 64'(gi), 64'd0);
    check_eq("fix_second_rdata", 64'(bus_f.data_mem_rdata), 64'(32'h0000_1204 ^ KEY));
    bus_f.data_read = 1'b0;
    wait_f(gi, lat);
    check_eq("fix_third_is_inst", 64'(gi), 64'd1);
    check_eq("fix_third_latency", 64'(lat), 64'd4);
    check_eq("fix_third_rdata", bus_f.inst_mem_rdata,
             {32'h0000_0304 ^ KEY, 32'h0000_0300 ^ KEY});
    bus_f.inst_read = 1'b0;
    @(negedge clk);

    // Reset while in the high fetch beat
    wait_n = 4;
    start_fetch(32'h0000_0400);
    k = 0;
    while (!(bus.pmem_read && bus.pmem_address[2]) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("reached_high_beat", 64'(bus.pmem_read & bus.pmem_address[2]), 64'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("async_rst_pmem_read", 64'(bus.pmem_read), 64'd0);
    check_eq("async_rst_inst_resp", 64'(bus.inst_mem_resp), 64'd0);
    bus.inst_read = 1'b0;
    exp_beat_q.delete(); exp_q.delete(); exp_dq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 force_resp = 1'b1;
    @(negedge clk);
    #1 force_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("late_resp_ignored", 64'({bus.inst_mem_resp, bus.data_mem_resp, bus.pmem_read, bus.pmem_write}), 64'd0);
    end

    // Randomized isolated transactions
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      w    = $urandom_range(0, 3);
      a    = (kind == 0) ? ($urandom & 32'h0000_0FFF) : (32'h0000_1000 | ($urandom & 32'h0000_0FFF));
      do_seq(kind, a, $urandom, 4'($urandom), w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check_eq("beats_left", 64'(exp_beat_q.size()), 64'd0);
    check_eq("inst_resp_left", 64'(exp_q.size()), 64'd0);
    check_eq("data_resp_left", 64'(exp_dq.size()), 64'd0);
    summary();
    $finish;
  end

endmodule
